ring_inject_arbiter: RTL and testbench

//  Per-ring-stop output scheduler for the PtRing. Shares one downstream ring link between two

---
 rtl/ring_arb_pkg.sv | 15 +
 rtl/ring_starve_ctr.sv | 52 +++++
 rtl/ring_inject_arbiter.sv | 92 +++++++++
 tb/tb_ring_inject_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ring_arb_pkg.sv
// Purpose: shared types and helpers for the ring-stop injection arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ring_arb_pkg;

  typedef enum logic [1:0] {GNT_NONE, GNT_RING, GNT_LOC} gnt_e;

  typedef enum logic {RING_PRI, LOC_FORCE} arb_st_e;

  // Counter width able to hold 0..max inclusive.
  function automatic int starveW(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/ring_starve_ctr.sv
// Purpose: counts consecutive ring wins while local waits; raises oForce at STARVE_MAX.
// Latency: oForce is registered, valid the cycle after the count reaches STARVE_MAX.
// Backpressure: none of its own; the caller only pulses inc on a real grant.
module ring_starve_ctr
  import ring_arb_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic oForce
);

  localparam int CW = starveW(STARVE_MAX);
  localparam logic [CW-1:0] MAXC = CW'(STARVE_MAX);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNext;
  arb_st_e       st;
  arb_st_e       stNext;

  // State and counter registers; synchronous active-low reset returns to ring priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      st  <= RING_PRI;
    end else begin
      cnt <= cntNext;
      st  <= stNext;
    end
  end

  // Saturating count and the force state it implies; clear wins over increment.
  always_comb begin
    cntNext = cnt;
    stNext  = st;
    if (clr) begin
      cntNext = '0;
    end else if (inc && (cnt != MAXC)) begin
      cntNext = cnt + 1'b1;
    end
    case (st)
      RING_PRI:  if (cntNext == MAXC) stNext = LOC_FORCE;
      LOC_FORCE: if (clr)             stNext = RING_PRI;
    endcase
  end

  assign oForce = (st == LOC_FORCE);

endmodule

// File: rtl/ring_inject_arbiter.sv
// Purpose: shares one ring link between ring pass-through and local injection, ring first,
//          with a starvation counter forcing a local grant after STARVE_MAX ring wins.
// Latency: pop to oVld is 1 cycle; back-to-back grants sustain 1 flit/cycle.
// Backpressure: when oVld & !iDnRdy the output register, counter and FSM hold and nothing pops.
module ring_inject_arbiter
  import ring_arb_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int STARVE_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iRingVld,
  input  logic [WIDTH-1:0] iRingDat,
  output logic             oRingPop,
  input  logic             iLocVld,
  input  logic [WIDTH-1:0] iLocDat,
  output logic             oLocPop,
  input  logic             iDnRdy,
  output logic             oVld,
  output logic [WIDTH-1:0] oDat,
  output logic             oGntLoc,
  output logic             oStarve
);

  gnt_e gnt;
  logic adv;
  logic locForce;
  logic forced;
  logic ctrInc;
  logic ctrClr;

  // Output slot is free when empty or when downstream takes the current flit this cycle.
  assign adv = !oVld || iDnRdy;

  // Grant selection: ring first unless the starvation FSM forces local; nothing while in reset.
  always_comb begin
    gnt    = GNT_NONE;
    forced = 1'b0;
    if (rst && adv) begin
      if (iRingVld && iLocVld) begin
        if (locForce) begin
          gnt    = GNT_LOC;
          forced = 1'b1;
        end else begin
          gnt = GNT_RING;
        end
      end else if (iRingVld) begin
        gnt = GNT_RING;
      end else if (iLocVld) begin
        gnt = GNT_LOC;
      end
    end
  end

  assign oRingPop = (gnt == GNT_RING);
  assign oLocPop  = (gnt == GNT_LOC);

  // A ring win only counts as starvation while local is actually waiting.
  assign ctrInc = (gnt == GNT_RING) && iLocVld;
  assign ctrClr = !iLocVld || (gnt == GNT_LOC);

  ring_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) uCtr (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctrInc),
    .clr   (ctrClr),
    .oForce(locForce)
  );

  // Output register: load on grant, drain when free with no grant, hold under backpressure.
  always_ff @(posedge clk) begin
    if (!rst) begin
      oVld    <= 1'b0;
      oDat    <= '0;
      oGntLoc <= 1'b0;
      oStarve <= 1'b0;
    end else if (adv) begin
      if (gnt != GNT_NONE) begin
        oVld    <= 1'b1;
        oDat    <= (gnt == GNT_LOC) ? iLocDat : iRingDat;
        oGntLoc <= (gnt == GNT_LOC);
        oStarve <= forced;
      end else begin
        oVld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ring_inject_arbiter.sv
// Purpose: directed table-driven bench for ring_inject_arbiter with STARVE_MAX=3.
// Latency: inputs driven on negedge; pops checked mid-cycle, registers checked after posedge.
// Backpressure: exercised through iDnRdy=0 rows and a forced grant held under stall.
module tb_ring_inject_arbiter;

  localparam int W  = 64;
  localparam int SM = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          iRingVld;
  logic [W-1:0]  iRingDat;
  logic          oRingPop;
  logic          iLocVld;
  logic [W-1:0]  iLocDat;
  logic          oLocPop;
  logic          iDnRdy;
  logic          oVld;
  logic [W-1:0]  oDat;
  logic          oGntLoc;
  logic          oStarve;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ring_inject_arbiter #(.WIDTH(W), .STARVE_MAX(SM)) dut (
    .clk     (clk),
    .rst     (rst),
    .iRingVld(iRingVld),
    .iRingDat(iRingDat),
    .oRingPop(oRingPop),
    .iLocVld (iLocVld),
    .iLocDat (iLocDat),
    .oLocPop (oLocPop),
    .iDnRdy  (iDnRdy),
    .oVld    (oVld),
    .oDat    (oDat),
    .oGntLoc (oGntLoc),
    .oStarve (oStarve)
  );

  typedef struct {
    logic         rst;
    logic         rv;
    logic [W-1:0] rd;
    logic         lv;
    logic [W-1:0] ld;
    logic         dn;
    logic         eRp;
    logic         eLp;
    logic         eVld;
    logic [W-1:0] eDat;
    logic         eGl;
    logic         eSt;
    int           eCnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic rv, input logic [W-1:0] rd,
                              input logic lv, input logic [W-1:0] ld, input logic dn,
                              input logic eRp, input logic eLp, input logic eVld,
                              input logic [W-1:0] eDat, input logic eGl, input logic eSt,
                              input int eCnt);
    vec_t v;
    v.rst = r;  v.rv = rv; v.rd = rd; v.lv = lv; v.ld = ld; v.dn = dn;
    v.eRp = eRp; v.eLp = eLp; v.eVld = eVld; v.eDat = eDat;
    v.eGl = eGl; v.eSt = eSt; v.eCnt = eCnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rv, input logic [W-1:0] rd,
                       input logic lv, input logic [W-1:0] ld, input logic dn);
    @(negedge clk);
    rst = r; iRingVld = rv; iRingDat = rd; iLocVld = lv; iLocDat = ld; iDnRdy = dn;
    #1;
  endtask

  task automatic afterEdge;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; iRingVld = 1'b0; iRingDat = '0; iLocVld = 1'b0; iLocDat = '0; iDnRdy = 1'b1;

    // 1: reset held with both sources valid: no pops, output stays empty.
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 1, 64'h11, 1, 64'h22, 1,  0, 0,  0, 64'h0, 0, 0, 0));
    // 2: ring only, then drain with oDat holding.
    vecs.push_back(mk(1, 1, 64'hA1, 0, 64'h0, 1,  1, 0,  1, 64'hA1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 64'h0, 0, 64'h0, 1,  0, 0,  0, 64'hA1, 0, 0, 0));
    // 3: both valid, STARVE_MAX=3 -> R,R,R,L,R,R,R,L.
    for (int i = 0; i < 8; i++) begin
      logic isL;
      int   c;
      isL = (i % 4) == 3;
      c   = isL ? 0 : (i % 4) + 1;
      vecs.push_back(mk(1, 1, 64'h100 + i, 1, 64'h200 + i, 1,
                        !isL, isL, 1, isL ? 64'h200 + i : 64'h100 + i, isL, isL, c));
    end
    // 4: load 0x55 from ring with local waiting, stall 4 cycles, then release.
    vecs.push_back(mk(1, 1, 64'h55, 1, 64'h66, 1,  1, 0,  1, 64'h55, 0, 0, 1));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 1, 64'h70 + i, 1, 64'h66, 0,  0, 0,  1, 64'h55, 0, 0, 1));
    vecs.push_back(mk(1, 1, 64'h77, 1, 64'h66, 1,  1, 0,  1, 64'h77, 0, 0, 2));
    // 5: ten back-to-back local flits, ring idle.
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1, 0, 64'h0, 1, 64'(i), 1,  0, 1,  1, 64'(i), 1, 0, 0));
    // 6 lead-in: two ring wins with local waiting -> cnt=2, oVld=1.
    vecs.push_back(mk(1, 1, 64'h301, 1, 64'h401, 1,  1, 0,  1, 64'h301, 0, 0, 1));
    vecs.push_back(mk(1, 1, 64'h302, 1, 64'h402, 1,  1, 0,  1, 64'h302, 0, 0, 2));

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].rv, vecs[k].rd, vecs[k].lv, vecs[k].ld, vecs[k].dn);
      chk($sformatf("v%0d ringPop", k), W'(oRingPop), W'(vecs[k].eRp));
      chk($sformatf("v%0d locPop", k),  W'(oLocPop),  W'(vecs[k].eLp));
      afterEdge();
      chk($sformatf("v%0d oVld", k),    W'(oVld),     W'(vecs[k].eVld));
      chk($sformatf("v%0d oDat", k),    oDat,         vecs[k].eDat);
      chk($sformatf("v%0d oGntLoc", k), W'(oGntLoc),  W'(vecs[k].eGl));
      chk($sformatf("v%0d oStarve", k), W'(oStarve),  W'(vecs[k].eSt));
      chk($sformatf("v%0d cnt", k),     W'(dut.uCtr.cnt), W'(vecs[k].eCnt));
    end

    // 6: one-cycle reset mid-operation discards the held flit and clears the counter.
    drive(0, 1, 64'h501, 1, 64'h601, 1);
    chk("rstMid ringPop", W'(oRingPop), '0);
    chk("rstMid locPop",  W'(oLocPop),  '0);
    afterEdge();
    chk("rstMid oVld", W'(oVld), '0);
    chk("rstMid cnt",  W'(dut.uCtr.cnt), '0);
    drive(1, 1, 64'h502, 1, 64'h602, 1);
    chk("postRst ringPop", W'(oRingPop), W'(1));
    chk("postRst locPop",  W'(oLocPop),  '0);
    afterEdge();
    chk("postRst oDat", oDat, 64'h502);
    chk("postRst cnt",  W'(dut.uCtr.cnt), W'(1));

    // Forced local grant pending while stalled: must wait, then fire on release.
    drive(1, 1, 64'h503, 1, 64'h603, 1);
    afterEdge();
    drive(1, 1, 64'h504, 1, 64'h604, 1);
    afterEdge();
    chk("starve cnt", W'(dut.uCtr.cnt), W'(3));
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 64'h505, 1, 64'h605, 0);
      chk($sformatf("stall%0d ringPop", i), W'(oRingPop), '0);
      chk($sformatf("stall%0d locPop", i),  W'(oLocPop),  '0);
      afterEdge();
      chk($sformatf("stall%0d oDat", i), oDat, 64'h504);
      chk($sformatf("stall%0d cnt", i),  W'(dut.uCtr.cnt), W'(3));
    end
    drive(1, 1, 64'h506, 1, 64'h606, 1);
    chk("force locPop",  W'(oLocPop),  W'(1));
    chk("force ringPop", W'(oRingPop), '0);
    afterEdge();
    chk("force oDat",    oDat,        64'h606);
    chk("force oGntLoc", W'(oGntLoc), W'(1));
    chk("force oStarve", W'(oStarve), W'(1));
    chk("force cnt",     W'(dut.uCtr.cnt), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
